mem_arbiter: RTL

Arbitrates the instruction-cache and data-cache miss and writeback traffic onto the single word-wide RAM port. Sits directly downstream of the data cache's `cif` request lines (`dREN`/`dWEN`/`daddr`/`dstore`) and the instruction cache's (`iREN`/`iaddr`). It returns `dwait`/`iwait` and the load data. Grants are registered, one word per grant, with data-side priority and a bounded starvation guard for instruction fetch.

---
 rtl/cpu_types_pkg.sv | 21 ++
 rtl/arb_stats.sv | 46 ++++
 rtl/mem_arbiter.sv | 132 +++++++++++++
 3 files changed

// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared word, RAM status and arbiter state types
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  // RAM port status as reported by the memory model/controller
  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  // Arbiter grant state
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DGRANT = 2'd1,
    IGRANT = 2'd2
  } arbstate_t;

endpackage

// File: rtl/arb_stats.sv
// rtl/arb_stats.sv - grant and instruction-stall counters for mem_arbiter (MEM_ARB_STATS_EN)
module arb_stats
  import cpu_types_pkg::*;
(
  input  logic  CLK,
  input  logic  RST,
  input  logic  dgrant_done_i,
  input  logic  igrant_done_i,
  input  logic  istall_i,
  output word_t stat_dgrants_o,
  output word_t stat_igrants_o,
  output word_t stat_istall_o
);

  word_t dgrants_q, dgrants_d;
  word_t igrants_q, igrants_d;
  word_t istall_q, istall_d;

  // next counts; plain 32-bit adds so each counter wraps modulo 2^32
  always_comb begin
    dgrants_d = dgrants_q;
    igrants_d = igrants_q;
    istall_d  = istall_q;
    if (dgrant_done_i) dgrants_d = dgrants_q + 32'd1;
    if (igrant_done_i) igrants_d = igrants_q + 32'd1;
    if (istall_i)      istall_d  = istall_q + 32'd1;
  end

  // counter registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      dgrants_q <= '0;
      igrants_q <= '0;
      istall_q  <= '0;
    end else begin
      dgrants_q <= dgrants_d;
      igrants_q <= igrants_d;
      istall_q  <= istall_d;
    end
  end

  assign stat_dgrants_o = dgrants_q;
  assign stat_igrants_o = igrants_q;
  assign stat_istall_o  = istall_q;

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - icache/dcache to single RAM port arbiter; optional stats via MEM_ARB_STATS_EN
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       iREN,
  input  word_t      iaddr,
  output word_t      iload,
  output logic       iwait,
  input  logic       dREN,
  input  logic       dWEN,
  input  word_t      daddr,
  input  word_t      dstore,
  output word_t      dload,
  output logic       dwait,
  output logic       ramREN,
  output logic       ramWEN,
  output word_t      ramaddr,
  output word_t      ramstore,
  input  word_t      ramload,
  input  logic [1:0] ramstate,
  output word_t      stat_dgrants,
  output word_t      stat_igrants,
  output word_t      stat_istall
);

  localparam int unsigned SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  arbstate_t     state_q, state_d;
  word_t         addr_q, addr_d;
  word_t         wdata_q, wdata_d;
  logic          wen_q, wen_d;
  logic [SW-1:0] starve_q, starve_d;

  logic dreq, access, granted, d_done, i_done;

  assign dreq    = dREN | dWEN;
  assign access  = (ramstate_t'(ramstate) == ACCESS);
  assign granted = (state_q != IDLE);
  assign d_done  = (state_q == DGRANT) && access;
  assign i_done  = (state_q == IGRANT) && access;

  // arbitration and latching of the winner; a grant is held until the RAM reports ACCESS
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wen_d   = wen_q;
    unique case (state_q)
      IDLE: begin
        if (dreq && (!iREN || (starve_q < STARVE_LIM))) begin
          state_d = DGRANT;
          addr_d  = daddr;
          wdata_d = dstore;
          wen_d   = dWEN;
        end else if (iREN) begin
          state_d = IGRANT;
          addr_d  = iaddr;
          wdata_d = '0;
          wen_d   = 1'b0;
        end
      end
      DGRANT, IGRANT: begin
        if (access) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // starvation counter: data completions while ifetch waits, saturating; cleared otherwise
  always_comb begin
    starve_d = starve_q;
    if (d_done) begin
      if (!iREN)                         starve_d = '0;
      else if (starve_q != STARVE_LIM)   starve_d = starve_q + SW'(1);
    end else if (i_done) begin
      starve_d = '0;
    end
  end

  // state and latched-request registers; reset drops strobes immediately via state_q
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      wen_q    <= 1'b0;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wen_q    <= wen_d;
      starve_q <= starve_d;
    end
  end

  assign ramREN   = granted && !wen_q;
  assign ramWEN   = granted && wen_q;
  assign ramaddr  = granted ? addr_q  : '0;
  assign ramstore = granted ? wdata_q : '0;

  assign dwait = !d_done;
  assign iwait = !i_done;
  assign dload = d_done ? ramload : '0;
  assign iload = i_done ? ramload : '0;

`ifdef MEM_ARB_STATS_EN
  logic istall;
  assign istall = iREN && iwait;

  arb_stats u_stats (
    .CLK            (CLK),
    .RST            (RST),
    .dgrant_done_i  (d_done),
    .igrant_done_i  (i_done),
    .istall_i       (istall),
    .stat_dgrants_o (stat_dgrants),
    .stat_igrants_o (stat_igrants),
    .stat_istall_o  (stat_istall)
  );
`else
  assign stat_dgrants = '0;
  assign stat_igrants = '0;
  assign stat_istall  = '0;
`endif

endmodule
